// File: rtl/beta_alu_mc.sv
// beta_alu_mc: ALU with a registered valid/ready result stage. MUL is a radix-2 shift-add
// multiplier that is only built when BETA_ALU_MC_MUL_EN is defined; otherwise 0010 is illegal.
module beta_alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_fn,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [1:0]       fsm_state
);
    localparam int SHW = $clog2(WIDTH);

`ifdef BETA_ALU_MC_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd2} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             start_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;
    logic [WIDTH-1:0] op_result;
    logic             op_illegal;
    logic             is_mul_op;
    logic [SHW-1:0]   shamt;

    // Handshake: a request transfers on a rising edge with in_valid && in_ready; a result
    // is consumed on a rising edge with out_valid && out_ready. Both may happen on one edge.
    assign in_ready  = rst_n && (state == S_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && is_mul_op;
    assign shamt     = in_b[SHW-1:0];
    assign fsm_state = state;

    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        is_mul_op  = 1'b0;
        case (alu_fn)
            4'b0000: op_result = in_a + in_b;
            4'b0001: op_result = in_a - in_b;
`ifdef BETA_ALU_MC_MUL_EN
            4'b0010: is_mul_op = 1'b1;
`endif
            4'b0100: op_result = {{(WIDTH-1){1'b0}}, in_a == in_b};
            4'b0101: op_result = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            4'b0110: op_result = {{(WIDTH-1){1'b0}}, $signed(in_a) <= $signed(in_b)};
            4'b1000: op_result = in_a & in_b;
            4'b1001: op_result = in_a | in_b;
            4'b1010: op_result = in_a ^ in_b;
            4'b1011: op_result = ~(in_a ^ in_b);
            4'b1100: op_result = in_a << shamt;
            4'b1101: op_result = in_a >> shamt;
            4'b1110: op_result = $signed(in_a) >>> shamt;
            default: op_illegal = 1'b1;
        endcase
    end

`ifdef BETA_ALU_MC_MUL_EN
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] acc_next;
    logic [SHW-1:0]   mul_cnt;

    // One multiplier bit per cycle: add the shifted multiplicand when the current bit is set.
    assign acc_next   = mul_acc + (mul_b[0] ? mul_a : '0);
    assign mul_done   = (state == S_MUL) && (mul_cnt == SHW'(WIDTH - 1));
    assign mul_result = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            mul_cnt <= '0;
        end else if (start_mul) begin
            mul_a   <= in_a;
            mul_b   <= in_b;
            mul_acc <= '0;
            mul_cnt <= '0;
        end else if (state == S_MUL) begin
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_acc <= acc_next;
            mul_cnt <= mul_cnt + SHW'(1);
        end
    end
`else
    assign mul_done   = 1'b0;
    assign mul_result = '0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
`ifdef BETA_ALU_MC_MUL_EN
                if (start_mul) state_next = S_MUL;
`endif
            end
`ifdef BETA_ALU_MC_MUL_EN
            S_MUL:  if (mul_done) state_next = S_HOLD;
`endif
            S_HOLD: if (out_valid && out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && !is_mul_op) begin
                out_valid   <= 1'b1;
                result      <= op_result;
                out_zero    <= (op_result == '0);
                out_illegal <= op_illegal;
            end else if (mul_done) begin
                out_valid   <= 1'b1;
                result      <= mul_result;
                out_zero    <= (mul_result == '0);
                out_illegal <= 1'b0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/beta_alu_mc.md
BETA_ALU_MC -- requirements
Module: beta_alu_mc

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits; legal values 8, 16, 32, 64.
REQ-002 Derived localparam SHW = log2(WIDTH): shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 alu_fn  input  4  operation code, per REQ-012.
REQ-008 in_a, in_b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result register holds an unconsumed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  WIDTH; out_zero  output  1  (result == 0); out_illegal  output  1  alu_fn was unsupported.

Function
REQ-012 Opcodes: 0000 ADD, 0001 SUB (a-b), 0010 MUL (low WIDTH bits), 0100 CMPEQ, 0101 CMPLT (signed), 0110 CMPLE (signed), 1000 AND, 1001 OR, 1010 XOR, 1011 XNOR, 1100 SHL, 1101 SHR (logical), 1110 SRA; all others illegal.
REQ-013 ADD/SUB wrap modulo 2^WIDTH; no carry/overflow output.
REQ-014 Compare results are zero-extended 1/0 in result[0].
REQ-015 Shifts use in_b[SHW-1:0] only; upper bits of in_b ignored.
REQ-016 Illegal opcode: result = 0, out_illegal = 1, single-cycle timing; out_illegal = 0 for all legal ops.
REQ-017 Transfer occurs on a rising edge with in_valid && in_ready; operands and alu_fn captured then and need not stay stable.
REQ-018 FSM states: IDLE, MUL, HOLD. in_ready = (state == IDLE) && (!out_valid || out_ready), combinational.
REQ-019 IDLE + accepted non-MUL op: result registered at the same edge; out_valid = 1 from the next cycle (latency 1); state stays IDLE.
REQ-020 IDLE + accepted MUL: state -> MUL; radix-2 shift-add over WIDTH iterations, one bit per cycle; out_valid rises exactly WIDTH cycles after the accept edge; state -> HOLD if out_valid then stays high, else IDLE.
REQ-021 HOLD: in_ready = 0; the state returns to IDLE on the edge where out_valid && out_ready.
REQ-022 out_valid stays high and result/out_zero/out_illegal stay stable until the edge where out_ready = 1.
REQ-023 Same-edge consume and accept (IDLE, out_valid, out_ready, in_valid): the old result is consumed and the new single-cycle result is loaded, so out_valid stays 1 with no bubble.
REQ-024 In MUL, in_valid is ignored (in_ready = 0); out_ready has no effect while out_valid = 0.
REQ-025 Back-to-back single-cycle ops with out_ready held at 1 give one result per cycle.

Reset
REQ-026 rst_n low forces immediately: state = IDLE, out_valid = 0, result = 0, out_zero = 0, out_illegal = 0, and the multiplier counter and accumulator = 0.
REQ-027 Reset during MUL aborts the operation; no result is produced after release.
REQ-028 in_ready is 0 while rst_n is low and is 1 in the first cycle after release.

Configuration
REQ-029 Macro BETA_ALU_MC_MUL_EN defined: MUL is implemented per REQ-020.
REQ-030 Macro BETA_ALU_MC_MUL_EN undefined: 0010 is an illegal opcode (REQ-016), the MUL state and datapath are not generated, and all other behaviour is unchanged.

Verification
REQ-031 WIDTH=32, ADD 0xFFFFFFFF+0x00000002, out_ready=1 -> next cycle result=0x00000001, out_zero=0, out_valid=1 for one cycle.
REQ-032 WIDTH=32, SUB 5-5 then CMPLT 0xFFFFFFFF,0x00000001 back-to-back -> results 0x0 with out_zero=1, then 0x1; one result per cycle.
REQ-033 MUL_EN defined, WIDTH=32, MUL 0x00010001*0x00010001 -> out_valid exactly 32 cycles after accept, result=0x00020001; in_ready=0 throughout.
REQ-034 SRA 0x80000000 by in_b=0x00000024 (amount 4), out_ready=0 for 3 cycles -> result=0xF8000000 held stable; in_ready=0 until out_ready=1.
REQ-035 Opcode 0111 -> result=0, out_illegal=1; with MUL_EN undefined, opcode 0010 -> same response.
REQ-036 rst_n low at MUL cycle 10 -> out_valid=0 immediately, no result after release, in_ready=1 in the first post-reset cycle.
